// File: rtl/pid_seq_pkg.sv
// Shared types and constants for the PID motion sequencer.
// Build option: PID_SEQ_FAST_SIM_EN selects a large ramp step for quick simulation.
package pid_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StRamp,
        StDecel
    } state_t;

`ifdef PID_SEQ_FAST_SIM_EN
    localparam logic [9:0] INC = 10'h020;
`else
    localparam logic [9:0] INC = 10'h003;
`endif

    // Braking is twice as aggressive as acceleration
    localparam logic [9:0] DEC = {INC[8:0], 1'b0};

    localparam logic [9:0]  FRWRD_MAX_DEF   = 10'h2A0;
    localparam logic [11:0] TURN_THRESH_DEF = 12'd44;

    // Magnitude of a signed 12-bit error; 13 bits so 12'h800 maps to +2048
    function automatic logic [12:0] abs_err(input logic [11:0] e);
        logic [12:0] x;
        x = {e[11], e};
        return x[12] ? (~x + 13'd1) : x;
    endfunction

endpackage

// File: rtl/pid_seq_frwrd_ramp.sv
// Forward-speed register with saturating up/down steps.
// Build option: PID_SEQ_FAST_SIM_EN (through pid_seq_pkg) sets the step size.
module frwrd_ramp
    import pid_seq_pkg::*;
#(
    parameter logic [9:0] FRWRD_MAX = FRWRD_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [9:0] frwrd
);

    logic [9:0]  frwrd_q;
    logic [9:0]  frwrd_d;
    logic [10:0] up_sum;

    // Next speed: clear wins, then increment (saturating), then decrement (floored at 0)
    always_comb begin
        frwrd_d = frwrd_q;
        up_sum  = {1'b0, frwrd_q} + {1'b0, INC};
        if (clr) begin
            frwrd_d = '0;
        end else if (inc) begin
            frwrd_d = (up_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : up_sum[9:0];
        end else if (dec) begin
            frwrd_d = (frwrd_q > DEC) ? (frwrd_q - DEC) : '0;
        end
    end

    // Speed register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frwrd_q <= '0;
        end else begin
            frwrd_q <= frwrd_d;
        end
    end

    assign frwrd = frwrd_q;

endmodule

// File: rtl/pid_seq.sv
// Motion sequencer feeding the wheel-speed PID: turn to heading, ramp up,
// count line crossings, ramp down, then report done.
// Build option: PID_SEQ_FAST_SIM_EN (through pid_seq_pkg) sets the ramp step size.
module pid_seq
    import pid_seq_pkg::*;
#(
    parameter logic [9:0]  FRWRD_MAX   = FRWRD_MAX_DEF,
    parameter logic [11:0] TURN_THRESH = TURN_THRESH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_go,
    input  logic [11:0] dsrd_hdg_in,
    input  logic [2:0]  squares,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic [11:0] error,
    output logic        err_vld,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [11:0] hdg_q;
    logic [2:0]  sq_q;
    logic [3:0]  line_cnt_q;
    logic        ir_q, ir_prev_q;
    logic [11:0] error_q;
    logic        err_vld_q;
    logic        done_q, done_d;
    logic        latch_cmd;
    logic        ramp_inc, ramp_dec, ramp_clr;
    logic        ir_rise;
    logic [12:0] err_mag;

    assign ir_rise = ir_q & ~ir_prev_q;
    assign err_mag = abs_err(error_q);

    // Next-state and ramp controls
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        latch_cmd = 1'b0;
        ramp_inc  = 1'b0;
        ramp_dec  = 1'b0;
        ramp_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ramp_clr = 1'b1;
                if (cmd_go) begin
                    latch_cmd = 1'b1;
                    state_d   = StTurn;
                end
            end
            StTurn: begin
                if (err_vld_q && (err_mag < {1'b0, TURN_THRESH})) begin
                    if (sq_q == 3'd0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRamp;
                    end
                end
            end
            StRamp: begin
                // Step still applies in the cycle the distance is reached
                ramp_inc = heading_rdy;
                if (line_cnt_q == {sq_q, 1'b0}) begin
                    state_d = StDecel;
                end
            end
            StDecel: begin
                if (heading_rdy) begin
                    ramp_dec = 1'b1;
                    if (frwrd <= DEC) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, command latches, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hdg_q   <= '0;
            sq_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (latch_cmd) begin
                hdg_q <= dsrd_hdg_in;
                sq_q  <= squares;
            end
        end
    end

    // Line sensor edge detect and crossing counter (counts only while ramping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= 1'b0;
            ir_prev_q  <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            ir_q      <= cntrIR;
            ir_prev_q <= ir_q;
            if (latch_cmd) begin
                line_cnt_q <= '0;
            end else if ((state_q == StRamp) && ir_rise) begin
                line_cnt_q <= line_cnt_q + 4'd1;
            end
        end
    end

    // Heading error, registered on each heading sample while a move is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q   <= '0;
            err_vld_q <= 1'b0;
        end else begin
            err_vld_q <= heading_rdy && (state_q != StIdle);
            if (heading_rdy && (state_q != StIdle)) begin
                error_q <= heading - hdg_q;
            end
        end
    end

    frwrd_ramp #(
        .FRWRD_MAX (FRWRD_MAX)
    ) u_frwrd_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ramp_inc),
        .dec   (ramp_dec),
        .clr   (ramp_clr),
        .frwrd (frwrd)
    );

    assign error   = error_q;
    assign err_vld = err_vld_q;
    assign moving  = (state_q != StIdle);
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule
